// File: rtl/counts_to_n.sv
// Bounded up/down counter with clear/load, saturate-or-wrap bounds, terminal-count pulse and sticky error.
// Latency: every action lands on the next clk edge; no backpressure, one action per cycle (clr > load > en).
module counts_to_n #(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = 3,
  parameter int WRAP    = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_zero,
  output logic             tc_pulse,
  output logic             err
);

  generate
    if ((WIDTH < 1) || (WIDTH > 30) || (MAX_VAL < 1) || (MAX_VAL > (2 ** WIDTH) - 1)) begin : g_bad_max
      $error("counts_to_n: MAX_VAL must lie in 1 .. 2**WIDTH-1");
    end
    if ((WRAP != 0) && (WRAP != 1)) begin : g_bad_wrap
      $error("counts_to_n: WRAP must be 0 or 1");
    end
  endgenerate

  // Bound compares run one bit wider so the all-ones MAX_VAL case stays a real comparison.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;
  logic             err_evt;
  logic             err_nxt;

  always_comb begin
    out_nxt = out;
    tc_nxt  = 1'b0;
    err_evt = 1'b0;
    if ({1'b0, out} > MAX_X) begin
      out_nxt = MAX_W;
      err_evt = 1'b1;
    end else if (clr) begin
      out_nxt = '0;
    end else if (load) begin
      if ({1'b0, load_val} > MAX_X) begin
        out_nxt = MAX_W;
        err_evt = 1'b1;
      end else begin
        out_nxt = load_val;
      end
    end else if (en) begin
      // Bound is tested before stepping so no carry/borrow ever reaches out.
      if (up_dn) begin
        if (out == MAX_W) begin
          tc_nxt  = 1'b1;
          out_nxt = (WRAP != 0) ? '0 : MAX_W;
        end else begin
          out_nxt = out + ONE;
        end
      end else begin
        if (out == '0) begin
          tc_nxt  = 1'b1;
          out_nxt = (WRAP != 0) ? MAX_W : '0;
        end else begin
          out_nxt = out - ONE;
        end
      end
    end
    err_nxt = err_evt | (err & ~err_clr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out      <= '0;
      tc_pulse <= 1'b0;
      err      <= 1'b0;
    end else begin
      out      <= out_nxt;
      tc_pulse <= tc_nxt;
      err      <= err_nxt;
    end
  end

  assign at_max  = (out == MAX_W);
  assign at_zero = (out == '0);

endmodule

// File: doc/counts_to_n.md
COUNTS_TO_N -- requirements
Module: counts_to_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, counter register width in bits.
REQ-002 The block SHALL have parameter MAX_VAL, default 3, highest legal count; legal range 1 <= MAX_VAL <= 2^WIDTH-1.
REQ-003 The block SHALL have parameter WRAP, default 0; 0 = saturate at bounds, 1 = wrap at bounds.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count-step request for this cycle.
REQ-007 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  load request.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 clr  input  1  synchronous clear of the count to 0.
REQ-011 err_clr  input  1  clears the sticky error flag.
REQ-012 out  output  WIDTH  current count, registered.
REQ-013 at_max  output  1  high when out == MAX_VAL, combinational from out.
REQ-014 at_zero  output  1  high when out == 0, combinational from out.
REQ-015 tc_pulse  output  1  registered one-cycle terminal-count pulse.
REQ-016 err  output  1  registered sticky error flag.

Function
REQ-017 Per-cycle priority SHALL be clr > load > en; at most one action takes effect per cycle.
REQ-018 clr SHALL set out to 0 next cycle regardless of load and en.
REQ-019 load with load_val <= MAX_VAL SHALL set out to load_val next cycle.
REQ-020 load with load_val > MAX_VAL SHALL set out to MAX_VAL (clamp) and set err next cycle.
REQ-021 en, up_dn=1, out < MAX_VAL SHALL increment out by 1; en, up_dn=0, out > 0 SHALL decrement out by 1.
REQ-022 WRAP=0: en with up_dn=1 at MAX_VAL SHALL hold MAX_VAL; en with up_dn=0 at 0 SHALL hold 0.
REQ-023 WRAP=1: en with up_dn=1 at MAX_VAL SHALL give 0; en with up_dn=0 at 0 SHALL give MAX_VAL.
REQ-024 tc_pulse SHALL be high for exactly the cycle after an en step is accepted at a bound (up at MAX_VAL or down at 0), in both modes; low otherwise, including when clr or load preempts en.
REQ-025 With en low, clr low and load low, out SHALL hold.
REQ-026 out SHALL never exceed MAX_VAL; if out > MAX_VAL is ever detected, out SHALL be forced to MAX_VAL and err set on the next edge.
REQ-027 err SHALL remain set until err_clr; if err_clr coincides with a new error event, err SHALL stay set.
REQ-028 All arithmetic SHALL be WIDTH bits with no carry or borrow reaching out; bound checks SHALL be made before stepping.
REQ-029 An illegal MAX_VAL (0 or >= 2^WIDTH) SHALL fail elaboration.

Reset
REQ-030 resetn low SHALL immediately and asynchronously force out=0, tc_pulse=0 and err=0, independent of clk.
REQ-031 While resetn is low, all inputs SHALL be ignored; the first edge after deassertion SHALL act on the inputs present at that edge.
REQ-032 Reset asserted mid-count or mid-pulse SHALL abort the operation with no residual tc_pulse or err.

Verification
REQ-033 Defaults; reset, then en=1, up_dn=1 for 6 cycles -> out 1,2,3,3,3,3; tc_pulse high in the cycle after each step requested at 3; at_max high from the 3rd cycle.
REQ-034 WRAP=1, WIDTH=3, MAX_VAL=5; out=5, en=1, up_dn=1 -> out=0 with tc_pulse=1; then en=1, up_dn=0 -> out=5 with tc_pulse=1.
REQ-035 Defaults; load=1, load_val=7 -> out=3, err=1; err_clr=1 the next cycle -> err=0; load_val=7 with err_clr=1 in the same cycle -> err stays 1.
REQ-036 Defaults; clr=1, load=1, load_val=2, en=1 together -> out=0, tc_pulse=0; then load=1, load_val=2, en=1 -> out=2.
REQ-037 Defaults; out=2, err=1; resetn pulsed low between clock edges -> out=0, err=0 immediately without a clock edge; the first edge after release counts from 0.
REQ-038 Random stimulus over WIDTH in {2,3,4} and both WRAP values -> out <= MAX_VAL in every cycle (assertion), and out matches a reference model every cycle.
